// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and types for the instruction-fetch stage.
//   NOP_INSTR        - bubble instruction (addi x0,x0,0)
//   RESET_PC_DEFAULT - default PC after reset
//   MAX_OUTST_DEFAULT- requests in flight / buffer depth
//   ibuf_entry_t     - {pc, instr} held in the instruction buffer
//   ifid_t           - contents of the IF/ID pipeline register
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam int          MAX_OUTST_DEFAULT = 2;
    localparam logic [1:0]  BUF_DEPTH         = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ibuf_entry_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc:       32'h0000_0000,
        pc_plus4: 32'h0000_0000,
        valid:    1'b0
    };

    function automatic ifid_t ifid_load(input logic [31:0] pc, input logic [31:0] instr);
        ifid_load = '{instr: instr, pc: pc, pc_plus4: pc + 32'd4, valid: 1'b1};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry synchronous FIFO.
//   clk, rst   - clock, synchronous active-high reset
//   clear      - empty the FIFO (wins over push/pop)
//   push/push_data - write an entry; accepted when not full, or when full
//                    and popping in the same cycle
//   pop        - drop the head entry (ignored when empty)
//   head_data  - current head entry (undefined when count == 0)
//   count      - number of valid entries (0..2)
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    // When full, the slot being written is the head being popped this cycle;
    // the head is read from the old contents, so this is safe.
    assign do_push = push && ((count_q != BUF_DEPTH) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the RV32IM 5-stage pipeline.
//   clk, rst             - clock, synchronous active-high reset
//   StallF/StallD/FlushD - hazard controls (hold PC, hold IF/ID, bubble IF/ID)
//   PCSrcE, PCTargetE    - redirect from Execute
//   ImemReq/Addr/Gnt     - request channel to instruction memory
//   ImemRValid/RData     - in-order response channel
//   InstrD/PCD/PCPlus4D/ValidD - IF/ID register outputs to Decode
// In-flight requests are split into "live" (response will be used) and
// "drop" (killed by a redirect, response discarded on arrival). Issue is
// credit-limited so that every live response always has a buffer slot.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          MAX_OUTST = MAX_OUTST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRValid,
    input  logic [31:0] ImemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam logic [2:0] CREDITS = 3'(MAX_OUTST);

    logic [31:0] pc_q, pc_d;
    logic [1:0]  live_q, live_d;
    logic [1:0]  drop_q, drop_d;
    ifid_t       ifid_q, ifid_d;

    logic [2:0]  inflight;
    logic [2:0]  occupancy;
    logic        hs;
    logic        rsp_any;
    logic        rsp_drop;
    logic        rsp_live;
    logic        bypass;

    logic [31:0] tag_head;
    logic [1:0]  tag_count;
    ibuf_entry_t ibuf_head;
    ibuf_entry_t ibuf_push_data;
    logic [1:0]  ibuf_count;
    logic        ibuf_push;
    logic        ibuf_pop;

    // ---------------- issue ----------------
    assign inflight  = {1'b0, live_q} + {1'b0, drop_q};
    assign occupancy = {1'b0, live_q} + {1'b0, ibuf_count};

    assign ImemReq  = !rst && !StallF && !PCSrcE
                      && (inflight < CREDITS) && (occupancy < CREDITS);
    assign ImemAddr = pc_q;
    assign hs       = ImemReq && ImemGnt;

    // ---------------- response classification ----------------
    // A response with nothing outstanding is spurious and ignored.
    assign rsp_any  = ImemRValid && (inflight != 3'd0);
    assign rsp_drop = rsp_any && (drop_q != 2'd0);
    // During a redirect the arriving response belongs to the old path.
    assign rsp_live = ImemRValid && (drop_q == 2'd0) && (tag_count != 2'd0) && !PCSrcE;

    assign bypass    = rsp_live && (ibuf_count == 2'd0) && !StallD && !FlushD;
    assign ibuf_push = rsp_live && !bypass;
    assign ibuf_pop  = !FlushD && !StallD && (ibuf_count != 2'd0);

    assign ibuf_push_data = '{pc: tag_head, instr: ImemRData};

    // PCs of in-flight live requests, in request order.
    fetch_buffer #(.W(32)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (PCSrcE),
        .push      (hs),
        .push_data (pc_q),
        .pop       (rsp_live),
        .head_data (tag_head),
        .count     (tag_count)
    );

    // Returned instructions waiting for Decode to accept them.
    fetch_buffer #(.W($bits(ibuf_entry_t))) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .clear     (PCSrcE),
        .push      (ibuf_push),
        .push_data (ibuf_push_data),
        .pop       (ibuf_pop),
        .head_data (ibuf_head),
        .count     (ibuf_count)
    );

    // ---------------- PC and counters ----------------
    always_comb begin
        pc_d   = pc_q;
        live_d = live_q;
        drop_d = drop_q;
        if (PCSrcE) begin
            pc_d   = PCTargetE;
            live_d = 2'd0;
            // Everything in flight becomes killed, except a response that
            // arrives (and is discarded) this very cycle.
            drop_d = inflight[1:0] - {1'b0, rsp_any};
        end else begin
            if (hs) begin
                pc_d = pc_q + 32'd4;
            end
            live_d = live_q + {1'b0, hs} - {1'b0, rsp_live};
            drop_d = drop_q - {1'b0, rsp_drop};
        end
    end

    // ---------------- IF/ID register ----------------
    always_comb begin
        ifid_d = ifid_q;
        if (FlushD) begin
            ifid_d = IFID_BUBBLE;
        end else if (StallD) begin
            ifid_d = ifid_q;
        end else if (ibuf_count != 2'd0) begin
            ifid_d = ifid_load(ibuf_head.pc, ibuf_head.instr);
        end else if (bypass) begin
            ifid_d = ifid_load(tag_head, ImemRData);
        end else begin
            ifid_d = IFID_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            live_q <= 2'd0;
            drop_q <= 2'd0;
            ifid_q <= IFID_BUBBLE;
        end else begin
            pc_q   <= pc_d;
            live_q <= live_d;
            drop_q <= drop_d;
            ifid_q <= ifid_d;
        end
    end

    assign InstrD   = ifid_q.instr;
    assign PCD      = ifid_q.pc;
    assign PCPlus4D = ifid_q.pc_plus4;
    assign ValidD   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The memory model returns 32'hA000_0000|addr,
// one cycle after the grant, in request order; mem_hold freezes responses.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRValid = 1'b0;
    logic [31:0] ImemRData  = 32'h0;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic        mem_hold;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemGnt    (ImemGnt),
        .ImemRValid (ImemRValid),
        .ImemRData  (ImemRData),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    always #5 clk = ~clk;

    logic [31:0] mq [$];
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            if (ImemRValid) void'(mq.pop_front());
            if (ImemReq && ImemGnt) mq.push_back(ImemAddr);
        end
        #2;
        ImemRValid = !mem_hold && (mq.size() > 0);
        ImemRData  = (mq.size() > 0) ? (32'hA000_0000 | mq[0]) : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc, input logic v);
        chk({tag, "_instr"}, InstrD, instr);
        chk({tag, "_pcd"}, PCD, pc);
        chk({tag, "_pcp4"}, PCPlus4D, v ? pc + 32'd4 : 32'd0);
        chk({tag, "_valid"}, {31'd0, ValidD}, {31'd0, v});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, ImemReq}, {31'd0, req});
        chk({tag, "_addr"}, ImemAddr, addr);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = 32'h0; ImemGnt = 1'b1; mem_hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_req("reset", 1'b0, 32'h0);
        chk_ifid("reset", NOP, 32'h0, 1'b0);

        // --- streaming with 1-cycle memory ---
        nxt(); rst = 1'b0;
        @(negedge clk); chk_req("c1", 1'b1, 32'h0); chk_ifid("c1", NOP, 32'h0, 1'b0);
        nxt(); @(negedge clk); chk_req("c2", 1'b1, 32'h4); chk_ifid("c2", NOP, 32'h0, 1'b0);
        nxt(); @(negedge clk); chk_ifid("c3", 32'hA000_0000, 32'h0, 1'b1);

        // --- StallD for 4 cycles: credits run out, buffer holds 0x8 and 0xC ---
        nxt(); StallD = 1'b1;
        @(negedge clk); chk_ifid("c4", 32'hA000_0004, 32'h4, 1'b1); chk_req("c4", 1'b1, 32'hC);
        nxt(); @(negedge clk); chk_req("c5", 1'b0, 32'h10); chk_ifid("c5", 32'hA000_0004, 32'h4, 1'b1);
        nxt(); @(negedge clk); chk_req("c6", 1'b0, 32'h10);
        nxt(); @(negedge clk); chk_req("c7", 1'b0, 32'h10); chk_ifid("c7", 32'hA000_0004, 32'h4, 1'b1);
        nxt(); StallD = 1'b0;
        @(negedge clk); chk_req("c8", 1'b0, 32'h10);
        nxt(); @(negedge clk); chk_ifid("c9", 32'hA000_0008, 32'h8, 1'b1); chk_req("c9", 1'b1, 32'h10);
        nxt(); @(negedge clk); chk_ifid("c10", 32'hA000_000C, 32'hC, 1'b1);

        // --- redirect with two requests in flight ---
        nxt(); mem_hold = 1'b1;
        @(negedge clk); chk_ifid("c11", 32'hA000_0010, 32'h10, 1'b1); chk_req("c11", 1'b1, 32'h18);
        nxt(); PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h100;
        @(negedge clk); chk_req("c12", 1'b0, 32'h1C); chk_ifid("c12", NOP, 32'h0, 1'b0);
        nxt(); PCSrcE = 1'b0; FlushD = 1'b0; mem_hold = 1'b0;
        @(negedge clk); chk_req("c13", 1'b0, 32'h100); chk_ifid("c13", NOP, 32'h0, 1'b0);
        nxt(); @(negedge clk); chk_req("c14", 1'b1, 32'h100); chk_ifid("c14", NOP, 32'h0, 1'b0);
        nxt(); @(negedge clk); chk_req("c15", 1'b1, 32'h104); chk_ifid("c15", NOP, 32'h0, 1'b0);

        // --- StallD + StallF + PCSrcE together ---
        nxt(); StallD = 1'b1; StallF = 1'b1; PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h200;
        @(negedge clk); chk_ifid("c16", 32'hA000_0100, 32'h100, 1'b1); chk_req("c16", 1'b0, 32'h108);
        nxt(); StallD = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; FlushD = 1'b0;
        @(negedge clk); chk_ifid("c17", NOP, 32'h0, 1'b0); chk_req("c17", 1'b1, 32'h200);
        nxt(); @(negedge clk); chk_req("c18", 1'b1, 32'h204);
        nxt(); @(negedge clk); chk_ifid("c19", 32'hA000_0200, 32'h200, 1'b1);

        // --- reset with two requests outstanding ---
        nxt(); mem_hold = 1'b1; StallD = 1'b1;
        @(negedge clk); chk_req("c20", 1'b1, 32'h20C); chk_ifid("c20", 32'hA000_0204, 32'h204, 1'b1);
        nxt(); rst = 1'b1;
        @(negedge clk); chk_req("c21", 1'b0, 32'h210);
        nxt(); rst = 1'b0; StallD = 1'b0; mem_hold = 1'b0;
        @(negedge clk); chk_ifid("r1", NOP, 32'h0, 1'b0); chk_req("r1", 1'b1, 32'h0);

        // --- grant withheld for 3 cycles at 0x10 ---
        nxt(); @(negedge clk); chk_req("r2", 1'b1, 32'h4);
        nxt(); @(negedge clk); chk_ifid("r3", 32'hA000_0000, 32'h0, 1'b1);
        nxt(); @(negedge clk); chk_ifid("r4", 32'hA000_0004, 32'h4, 1'b1);
        nxt(); ImemGnt = 1'b0;
        @(negedge clk); chk_req("r5", 1'b1, 32'h10); chk_ifid("r5", 32'hA000_0008, 32'h8, 1'b1);
        nxt(); @(negedge clk); chk_req("r6", 1'b1, 32'h10); chk_ifid("r6", 32'hA000_000C, 32'hC, 1'b1);
        nxt(); @(negedge clk); chk_req("r7", 1'b1, 32'h10); chk_ifid("r7", NOP, 32'h0, 1'b0);
        nxt(); ImemGnt = 1'b1;
        @(negedge clk); chk_req("r8", 1'b1, 32'h10);
        nxt(); @(negedge clk); chk_req("r9", 1'b1, 32'h14); chk_ifid("r9", NOP, 32'h0, 1'b0);
        nxt(); @(negedge clk); chk_ifid("r10", 32'hA000_0010, 32'h10, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
